// File: rtl/poly_arith_pkg.sv
// Shared arithmetic types for the ML-KEM arithmetic unit: coefficient type,
// butterfly mode tags, the modulus, and the PE output beat payload.
package poly_arith_pkg;

   localparam int unsigned KYBER_Q = 3329;
   localparam int unsigned COEFF_W = 12;

   typedef logic [COEFF_W-1:0] coeff_t;

   // Encodings 3'd6 and 3'd7 are undefined; the PE answers them with zeros.
   typedef enum logic [2:0] {
      MODE_NTT    = 3'd0,
      MODE_INTT   = 3'd1,
      MODE_CWM    = 3'd2,
      MODE_COMP   = 3'd3,
      MODE_DECOMP = 3'd4,
      MODE_ADDSUB = 3'd5
   } pe_mode_e;

   // One result beat as stored in the PE output FIFO.
   typedef struct packed {
      coeff_t   u;
      coeff_t   v;
      pe_mode_e mode;
   } pe_beat_t;

endpackage

// File: rtl/pe_bfly_pipe_arith.sv
// Modular arithmetic building blocks and a generic delay line used by the
// butterfly PE. All operands are assumed already reduced (< Q).

// Fixed-depth shift register; optional clear on rst (used for valid/tag lines).
module delay_n #(
   parameter int DWIDTH  = 1,
   parameter int DEPTH   = 1,
   parameter bit HAS_RST = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] d,
   output logic [DWIDTH-1:0] q
);
   logic [DWIDTH-1:0] pipe [DEPTH];

   // Shift one stage per clock; data-only lines skip the reset.
   always_ff @(posedge clk) begin
      if (HAS_RST && rst) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= d;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign q = pipe[DEPTH-1];
endmodule

// (a + b) mod Q.
module mod_add #(
   parameter int W = 12,
   parameter int Q = 3329
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
   logic [W:0] s;

   // One conditional subtract suffices since a, b < Q.
   always_comb begin
      s = {1'b0, a} + {1'b0, b};
      y = (s >= (W+1)'(Q)) ? W'(s - (W+1)'(Q)) : W'(s);
   end
endmodule

// (a - b) mod Q.
module mod_sub #(
   parameter int W = 12,
   parameter int Q = 3329
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
   // Wrap-around in W bits is harmless: the true result lies in [0, Q).
   always_comb begin
      y = (a >= b) ? (a - b) : (a - b + W'(Q));
   end
endmodule

// x / 2 mod Q: even x shifts, odd x adds Q first (Q odd makes the sum even).
module mod_div_by_2 #(
   parameter int W = 12,
   parameter int Q = 3329
) (
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);
   logic [W:0] s;

   // Widen by one bit so x + Q cannot overflow before the shift.
   always_comb begin
      s = {1'b0, x} + (x[0] ? (W+1)'(Q) : '0);
      y = W'(s >> 1);
   end
endmodule

// (a * b) mod Q with LAT register stages after the reduction.
module mod_mul #(
   parameter int W   = 12,
   parameter int Q   = 3329,
   parameter int LAT = 2
) (
   input  logic         clk,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
   logic [2*W-1:0] prod;
   logic [W-1:0]   red;

   // Full product then constant-modulus reduction; the pipe lets synthesis retime.
   always_comb begin
      prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      red  = W'(prod % (2*W)'(Q));
   end

   delay_n #(.DWIDTH(W), .DEPTH(LAT), .HAS_RST(1'b0)) u_pipe (
      .clk (clk),
      .rst (1'b0),
      .d   (red),
      .q   (y)
   );
endmodule

// File: rtl/pe_out_fifo.sv
// Synchronous first-word-fall-through FIFO for PE result beats. The head is
// visible whenever count != 0 and reads as zero when empty. Writers must
// respect the exposed count; there is no overflow protection.
module pe_out_fifo
   import poly_arith_pkg::*;
#(
   parameter int  DEPTH  = 6,
   parameter type beat_t = pe_beat_t,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  beat_t         wr_data,
   input  logic          rd_en,
   output beat_t         rd_data,
   output logic [CW-1:0] count
);
   beat_t         mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop  = rd_en && (count != '0);
   assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

   // Payload storage is never reset; only pointers and count define contents.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem[wr_ptr] <= wr_data;
   end

   // Pointer and occupancy bookkeeping; write and pop may share an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)  wr_ptr <= ptr_next(wr_ptr);
         if (do_pop) rd_ptr <= ptr_next(rd_ptr);
         count <= count + CW'(wr_en) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/pe_bfly_pipe.sv
// Pipelined six-mode butterfly PE with per-beat mode tags, fixed latency
// LAT = MUL_LAT + 2 for every mode, and a credit-controlled output FIFO.
//
// Handshakes: input beat transfers on a rising edge with valid_i && ready_o;
// output beat transfers on a rising edge with valid_o && ready_i. ready_o is
// a function of registered credit state and rst only, and valid_o of FIFO
// occupancy and rst only, so neither handshake has a combinational loop.
module pe_bfly_pipe
   import poly_arith_pkg::*;
#(
   parameter int COEFF_WIDTH = 12,
   parameter int Q           = KYBER_Q,
   parameter int MUL_LAT     = 2,
   parameter int FIFO_DEPTH  = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [COEFF_WIDTH-1:0] a_i,
   input  logic [COEFF_WIDTH-1:0] b_i,
   input  logic [COEFF_WIDTH-1:0] w_i,
   input  pe_mode_e               mode_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   output logic [COEFF_WIDTH-1:0] u_o,
   output logic [COEFF_WIDTH-1:0] v_o,
   output pe_mode_e               mode_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic                   busy_o
);
   localparam int W   = COEFF_WIDTH;
   localparam int LAT = MUL_LAT + 2;
   localparam int MW  = $bits(pe_mode_e);
   localparam int IW  = $clog2(LAT + 1);
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int SW  = $clog2(LAT + FIFO_DEPTH + 1) + 1;

   typedef logic [W-1:0] cw_t;
   typedef struct packed {
      cw_t      u;
      cw_t      v;
      pe_mode_e mode;
   } beat_t;

   if (Q >= (1 << COEFF_WIDTH)) begin : g_chk_q_range
      $error("Q must be below 2**COEFF_WIDTH");
   end
   if ((Q % 2) == 0) begin : g_chk_q_odd
      $error("Q must be odd");
   end
   if (FIFO_DEPTH < 1) begin : g_chk_fifo
      $error("FIFO_DEPTH must be at least 1");
   end
   if (MUL_LAT < 1) begin : g_chk_mul_lat
      $error("MUL_LAT must be at least 1");
   end

   logic          accept;
   logic [IW-1:0] inflight;
   logic [CW-1:0] fifo_cnt;

   assign accept = valid_i && ready_o;

   // ---- valid/tag line: the staged tag drives every result select ----
   logic [MW:0] tag_q;
   logic        tag_v;
   pe_mode_e    tag_mode;

   delay_n #(.DWIDTH(MW + 1), .DEPTH(LAT), .HAS_RST(1'b1)) u_tag (
      .clk (clk),
      .rst (rst),
      .d   ({accept, mode_i}),
      .q   (tag_q)
   );
   assign tag_v    = tag_q[MW];
   assign tag_mode = pe_mode_e'(tag_q[MW-1:0]);

   // ---- INTT / ADDSUB front: add/sub on raw operands ----
   cw_t sum_c, diff_c;
   cw_t s1_sum, s1_diff, s1_w;
   cw_t half_c, half_d, intt_prod;
   cw_t as_u, as_v;

   mod_add #(.W(W), .Q(Q)) u_add_in (.a(a_i), .b(b_i), .y(sum_c));
   mod_sub #(.W(W), .Q(Q)) u_sub_in (.a(a_i), .b(b_i), .y(diff_c));

   // First stage of the INTT and ADDSUB paths.
   always_ff @(posedge clk) begin
      s1_sum  <= sum_c;
      s1_diff <= diff_c;
      s1_w    <= w_i;
   end

   mod_div_by_2 #(.W(W), .Q(Q)) u_half (.x(s1_sum), .y(half_c));

   delay_n #(.DWIDTH(W), .DEPTH(MUL_LAT), .HAS_RST(1'b0)) u_half_dly (
      .clk (clk),
      .rst (1'b0),
      .d   (half_c),
      .q   (half_d)
   );

   mod_mul #(.W(W), .Q(Q), .LAT(MUL_LAT)) u_mul_intt (
      .clk (clk),
      .a   (s1_diff),
      .b   (s1_w),
      .y   (intt_prod)
   );

   delay_n #(.DWIDTH(2 * W), .DEPTH(LAT - 1), .HAS_RST(1'b0)) u_as_dly (
      .clk (clk),
      .rst (1'b0),
      .d   ({s1_sum, s1_diff}),
      .q   ({as_u, as_v})
   );

   // ---- NTT / CWM / COMP / DECOMP front: B*W on raw operands ----
   cw_t bw, a_d, ntt_add_c, ntt_sub_c;
   cw_t x_add, x_sub, x_a, x_bw;
   cw_t y_ntt_u, y_ntt_v, y_a, y_bw, y_intt_u, y_intt_v;

   mod_mul #(.W(W), .Q(Q), .LAT(MUL_LAT)) u_mul_bw (
      .clk (clk),
      .a   (b_i),
      .b   (w_i),
      .y   (bw)
   );

   delay_n #(.DWIDTH(W), .DEPTH(MUL_LAT), .HAS_RST(1'b0)) u_a_dly (
      .clk (clk),
      .rst (1'b0),
      .d   (a_i),
      .q   (a_d)
   );

   mod_add #(.W(W), .Q(Q)) u_add_ntt (.a(a_d), .b(bw), .y(ntt_add_c));
   mod_sub #(.W(W), .Q(Q)) u_sub_ntt (.a(a_d), .b(bw), .y(ntt_sub_c));

   // Butterfly add/sub stage, with A and B*W carried alongside for COMP/DECOMP.
   always_ff @(posedge clk) begin
      x_add <= ntt_add_c;
      x_sub <= ntt_sub_c;
      x_a   <= a_d;
      x_bw  <= bw;
   end

   // Final result registers of every path, aligned with the tag line output.
   always_ff @(posedge clk) begin
      y_ntt_u  <= x_add;
      y_ntt_v  <= x_sub;
      y_a      <= x_a;
      y_bw     <= x_bw;
      y_intt_u <= half_d;
      y_intt_v <= intt_prod;
   end

   // ---- result select on the staged tag ----
   beat_t wr_beat;

   // Pick the path matching the beat's own tag; undefined tags yield zeros.
   always_comb begin
      wr_beat      = '0;
      wr_beat.mode = tag_mode;
      case (tag_mode)
         MODE_NTT, MODE_CWM: begin
            wr_beat.u = y_ntt_u;
            wr_beat.v = y_ntt_v;
         end
         MODE_INTT: begin
            wr_beat.u = y_intt_u;
            wr_beat.v = y_intt_v;
         end
         MODE_COMP, MODE_DECOMP: begin
            wr_beat.u = y_a;
            wr_beat.v = y_bw;
         end
         MODE_ADDSUB: begin
            wr_beat.u = as_u;
            wr_beat.v = as_v;
         end
         default: ;
      endcase
   end

   // ---- output FIFO and credit accounting ----
   beat_t head;
   logic  pop;

   assign pop = valid_o && ready_i;

   pe_out_fifo #(.DEPTH(FIFO_DEPTH), .beat_t(beat_t)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (tag_v),
      .wr_data (wr_beat),
      .rd_en   (pop),
      .rd_data (head),
      .count   (fifo_cnt)
   );

   // Beats accepted but not yet written to the FIFO.
   always_ff @(posedge clk) begin
      if (rst) inflight <= '0;
      else     inflight <= inflight + IW'(accept) - IW'(tag_v);
   end

   // Every accepted beat already owns a FIFO slot, so the FIFO cannot overflow.
   assign ready_o = !rst && ((SW'(inflight) + SW'(fifo_cnt)) < SW'(FIFO_DEPTH));
   assign valid_o = !rst && (fifo_cnt != '0);
   assign busy_o  = !rst && ((inflight != '0) || (fifo_cnt != '0));
   assign u_o     = valid_o ? head.u : '0;
   assign v_o     = valid_o ? head.v : '0;
   assign mode_o  = valid_o ? head.mode : pe_mode_e'(3'd0);

endmodule

// File: tb/tb_pe_bfly_pipe.sv
// Scoreboard bench for pe_bfly_pipe at default parameters (Q = 3329, LAT = 4,
// FIFO depth 6). Directed vectors push hand-computed results; a negedge
// monitor pops and compares every transferred output beat.
module tb_pe_bfly_pipe;
   import poly_arith_pkg::*;

   localparam int W  = 12;
   localparam int EW = 3 + 2 * W;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a_i, b_i, w_i;
   pe_mode_e     mode_i;
   logic         valid_i;
   logic         ready_o;
   logic [W-1:0] u_o, v_o;
   pe_mode_e     mode_o;
   logic         valid_o;
   logic         ready_i;
   logic         busy_o;

   pe_bfly_pipe dut (
      .clk     (clk),
      .rst     (rst),
      .a_i     (a_i),
      .b_i     (b_i),
      .w_i     (w_i),
      .mode_i  (mode_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .u_o     (u_o),
      .v_o     (v_o),
      .mode_o  (mode_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .busy_o  (busy_o)
   );

   // ---- clock / reset block ----
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // ---- bookkeeping ----
   int n_checks = 0;
   int n_pass   = 0;
   int n_acc    = 0;
   int n_pop    = 0;
   int n_valid  = 0;
   int last_acc_cyc = 0;
   int last_pop_cyc = 0;
   int pop_cyc_q[$];
   logic [EW-1:0] exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // ---- driver tasks ----
   task automatic send(input pe_mode_e m, input int a, input int b, input int w,
                       input bit push, input int eu, input int ev);
      bit took;
      int waited;
      took   = 1'b0;
      waited = 0;
      mode_i  = m;
      a_i     = W'(a);
      b_i     = W'(b);
      w_i     = W'(w);
      valid_i = 1'b1;
      while (!took && waited < 200) begin
         took = ready_o;
         @(posedge clk);
         #1;
         waited++;
      end
      valid_i = 1'b0;
      if (took) begin
         n_acc++;
         last_acc_cyc = cyc;
         if (push) exp_q.push_back({m, W'(eu), W'(ev)});
      end else begin
         check("accept_timeout", int'(took), 1);
      end
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy_o) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---- scoreboard monitor ----
   always @(negedge clk) begin
      logic [EW-1:0] got;
      logic [EW-1:0] exp;
      if (valid_o) n_valid++;
      if (valid_o && ready_i) begin
         got = {mode_o, u_o, v_o};
         n_pop++;
         last_pop_cyc = cyc;
         pop_cyc_q.push_back(cyc);
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got u=%0d v=%0d mode=%0d, expected no beat",
                     u_o, v_o, mode_o);
         end else begin
            exp = exp_q.pop_front();
            if (got == exp) n_pass++;
            else $display("FAIL sb_beat: got u=%0d v=%0d mode=%0d, expected u=%0d v=%0d mode=%0d",
                          got[2*W-1:W], got[W-1:0], got[EW-1:2*W],
                          exp[2*W-1:W], exp[W-1:0], exp[EW-1:2*W]);
         end
      end
   end

   // ---- directed sequence ----
   initial begin
      int v0, p0, a0;
      rst     = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b1;
      a_i     = '0;
      b_i     = '0;
      w_i     = '0;
      mode_i  = MODE_NTT;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", int'(valid_o), 0);
      check("rst_busy",  int'(busy_o),  0);
      check("rst_ready", int'(ready_o), 0);
      check("rst_u",     int'(u_o),     0);
      check("rst_v",     int'(v_o),     0);
      check("rst_mode",  int'(mode_o),  0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("ready_after_rst", int'(ready_o), 1);

      // Single NTT: latency 4, valid for exactly one cycle
      v0 = n_valid;
      send(MODE_NTT, 100, 2, 17, 1'b1, 134, 66);
      wait_drain("ntt_drain");
      check("ntt_latency", last_pop_cyc - last_acc_cyc, 4);
      check("ntt_valid_cycles", n_valid - v0, 1);

      // Single INTT
      send(MODE_INTT, 1, 2, 10, 1'b1, 1666, 3319);
      wait_drain("intt_drain");
      check("intt_latency", last_pop_cyc - last_acc_cyc, 4);

      // Back-to-back with a mode switch on every beat
      pop_cyc_q.delete();
      send(MODE_NTT,    100, 2,   17, 1'b1, 134, 66);
      send(MODE_ADDSUB, 3000, 500, 9, 1'b1, 171, 2500);
      send(MODE_COMP,   5,   3,   4,  1'b1, 5,   12);
      wait_drain("b2b_drain");
      check("b2b_count", pop_cyc_q.size(), 3);
      if (pop_cyc_q.size() == 3)
         check("b2b_consecutive", pop_cyc_q[2] - pop_cyc_q[0], 2);
      check("b2b_latency", last_pop_cyc - last_acc_cyc, 4);

      // Backpressure: ready_i low while 10 beats are offered
      ready_i = 1'b0;
      a0 = n_acc;
      p0 = n_pop;
      fork
         begin
            for (int i = 1; i <= 10; i++) begin
               if (i % 2 == 0) send(MODE_ADDSUB, 10 * i, i, 0, 1'b1, 11 * i, 9 * i);
               else            send(MODE_COMP,   i,      i, 3, 1'b1, i,      3 * i);
            end
         end
         begin
            repeat (20) @(posedge clk);
            #3;
            check("bp_accepted", n_acc - a0, 6);
            check("bp_ready_low", int'(ready_o), 0);
            check("bp_valid_held", int'(valid_o), 1);
            check("bp_no_pop", n_pop - p0, 0);
            ready_i = 1'b1;
         end
      join
      wait_drain("bp_drain");
      check("bp_popped", n_pop - p0, 10);
      check("bp_ready_recovered", int'(ready_o), 1);

      // Reset with three beats in flight and two buffered
      ready_i = 1'b0;
      send(MODE_NTT, 1, 1, 1, 1'b0, 0, 0);
      send(MODE_NTT, 2, 2, 2, 1'b0, 0, 0);
      repeat (5) @(posedge clk);
      #1;
      send(MODE_ADDSUB, 3, 3, 3, 1'b0, 0, 0);
      send(MODE_COMP,   4, 4, 4, 1'b0, 0, 0);
      send(MODE_INTT,   5, 5, 5, 1'b0, 0, 0);
      rst = 1'b1;
      #1;
      check("midrst_valid", int'(valid_o), 0);
      check("midrst_busy",  int'(busy_o),  0);
      check("midrst_ready", int'(ready_o), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("postrst_ready", int'(ready_o), 1);
      check("postrst_busy",  int'(busy_o),  0);
      v0 = n_valid;
      ready_i = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("postrst_no_ghost", n_valid - v0, 0);

      // Boundaries and remaining modes
      send(MODE_NTT,    3328, 3328, 3328, 1'b1, 0,    3327);
      send(MODE_NTT,    0,    0,    3328, 1'b1, 0,    0);
      send(pe_mode_e'(3'd7), 100, 2, 17,  1'b1, 0,    0);
      send(MODE_CWM,    100,  2,    17,   1'b1, 134,  66);
      send(MODE_DECOMP, 7,    5,    6,    1'b1, 7,    30);
      send(MODE_ADDSUB, 0,    1,    0,    1'b1, 1,    3328);
      send(MODE_INTT,   3328, 3328, 5,    1'b1, 3328, 0);
      wait_drain("bound_drain");

      check("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/pe_bfly_pipe.md
# pe_bfly_pipe

Parametrised successor to the single-mode-per-flush butterfly PE in the ML-KEM arithmetic unit. It computes the same six-mode butterfly set, but with these differences:
- operand width, modulus and multiplier depth are parameters;
- every beat carries its own mode tag, so the AU controller can switch modes on any cycle without flushing;
- all modes share one fixed latency;
- a credit-controlled output FIFO gives ready/valid backpressure toward the downstream memory/transpose stage.

## Interface
Parameters:
- COEFF_WIDTH, default 12: coefficient width in bits.
- Q, default 3329: modulus. Must satisfy Q < 2^COEFF_WIDTH and Q odd.
- MUL_LAT, default 2: register stages inside the modular multiplier.
- FIFO_DEPTH, default 6: output FIFO entries. Must be ≥ 1. Full throughput requires FIFO_DEPTH ≥ MUL_LAT+4.

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- a_i, b_i, w_i, in, COEFF_WIDTH each: operands A, B and twiddle W. Each must be < Q.
- mode_i, in, pe_mode_e: operation for this beat.
- valid_i, in, 1: input beat valid.
- ready_o, out, 1: input may be accepted.
- u_o, v_o, out, COEFF_WIDTH each: result pair.
- mode_o, out, pe_mode_e: mode tag of the presented result.
- valid_o, out, 1: result valid.
- ready_i, in, 1: downstream accepts.
- busy_o, out, 1: any beat in flight or held in the FIFO.

## Operation
- A beat is accepted on an edge where valid_i && ready_o.
- Results, all mod Q and all < Q:
  - NTT, CWM: u = A+B·W, v = A−B·W.
  - INTT: u = (A+B)/2, v = (A−B)·W. Halving of x: x even → x>>1; x odd → (x+Q)>>1.
  - COMP, DECOMP: u = A, v = B·W.
  - ADDSUB: u = A+B, v = A−B.
  - Any other encoding: u = 0, v = 0, tag echoed.
- Mode handling:
  - The mode tag and valid bit travel through the datapath alongside the data.
  - All datapath muxes select on the staged tag, never on mode_i.
  - mode_i may differ on every accepted beat.
- Latency and ordering:
  - Short modes (COMP/DECOMP/ADDSUB) are padded to LAT = MUL_LAT+2.
  - Results leave in acceptance order; there is no reordering.
- Credit accounting:
  - inflight = beats accepted but not yet written to the FIFO (0..LAT).
  - fifo_cnt = FIFO occupancy (0..FIFO_DEPTH).
  - ready_o = !rst && (inflight + fifo_cnt < FIFO_DEPTH).
  - ready_o depends only on registered state, never combinationally on ready_i or valid_i.
  - Because of this rule the FIFO can never overflow; there is no overflow path.
- Simultaneous events: accept, FIFO write and FIFO pop may all occur on one edge. Counters update by the net effect.
- Output FIFO behaviour:
  - First-word-fall-through.
  - valid_o = (fifo_cnt ≠ 0).
  - The head is popped on valid_o && ready_i.
  - When valid_o = 0, u_o, v_o and mode_o are driven to 0.
- busy_o = (inflight ≠ 0) || (fifo_cnt ≠ 0).
- Reset:
  - Clears the valid/tag pipeline, inflight, the FIFO pointers and fifo_cnt.
  - Data registers are not reset.
  - Reset mid-operation discards every in-flight and buffered beat; none of them ever appears on the outputs.
- Outputs while rst is high and on the edge after it: valid_o = 0, busy_o = 0, u_o/v_o/mode_o = 0, ready_o = 0.
- First cycle after rst deasserts: ready_o = 1.

## Timing
- A beat accepted at edge k is written to the FIFO at edge k+LAT.
  - valid_o is high in the cycle after edge k+LAT when the FIFO was empty.
  - With defaults this is 4 cycles.
- Throughput is one beat per cycle whenever ready_i stays high and FIFO_DEPTH ≥ LAT+2.
- Smaller FIFO_DEPTH stays functionally correct but reduces throughput.
- INTT staging:
  - Cycle 1: add/sub registered, sum halved, halved sum pushed into a delay line.
  - Cycles 2 to MUL_LAT+1: difference times W through the multiplier.
  - Cycle LAT: write to the FIFO.
- NTT/CWM staging:
  - Cycles 1 to MUL_LAT: B·W through the multiplier, with A delayed MUL_LAT.
  - Cycle MUL_LAT+1: add/sub registered.
  - Cycle LAT: write to the FIFO.
- COMP/DECOMP: multiplier plus delay padding to LAT.
- ADDSUB: add/sub plus LAT−1 padding registers.
- There is no combinational path from ready_i to ready_o, or from valid_i to valid_o.

## Structure
- The shared package poly_arith_pkg holds coeff_t, pe_mode_e and the Q constant. Add pe_beat_t {u, v, mode} there for the FIFO payload.
- Reused sub-blocks: mod_add, mod_sub, mod_mul, mod_div_by_2, delay_n.
  - Tag/valid pipeline: delay_n with DWIDTH = $bits(pe_mode_e)+1, DEPTH = LAT.
  - Padding lines: delay_n.
- New sub-module: pe_out_fifo, a synchronous FWFT FIFO with parameters DEPTH and pe_beat_t payload. It exposes its count for credit logic.
- Elaboration-time assertions: Q < 2^COEFF_WIDTH, Q odd, FIFO_DEPTH ≥ 1.

## Test plan
- NTT, a=100, b=2, w=17, ready_i=1 → after 4 cycles: u=134, v=66, mode_o=NTT, valid_o high for exactly one cycle.
- INTT, a=1, b=2, w=10 → u=1666, v=3319.
- Back-to-back beats on consecutive cycles, with the mode switching on every beat and no flush between them:
  - NTT (100, 2, 17), then ADDSUB (3000, 500, x), then COMP (5, 3, 4).
  - Expected on three consecutive cycles: (134, 66), (171, 2500), (5, 12), with correct mode_o tags.
- ready_i held low while 10 beats are streamed:
  - Exactly 6 are accepted; ready_o then stays low.
  - After ready_i is raised, all 10 results emerge in order with none lost or duplicated, and ready_o recovers.
- Three beats in flight plus two buffered, then rst pulsed for one cycle:
  - valid_o never rises for the discarded beats.
  - busy_o = 0 after reset; ready_o = 1 on the first cycle after rst deasserts.
- Boundaries:
  - NTT a=3328, b=3328, w=3328 → u=0, v=3327.
  - NTT a=0, b=0, w=3328 → u=0, v=0.
  - Undefined mode encoding → u=0, v=0, tag echoed.
